// File: rtl/stopwatch_control_fsm.sv
// ---------------------------------------------------------------------------
// stopwatch_control_fsm
//
// Control front end for the seconds-counter / 7-segment timer datapath.
// Conditions the two raw push-buttons (2-FF sync + debounce), classifies
// them into start, lap and long-press events, and sequences the timer
// through IDLE, RUN, PAUSE and LAP. Produces the 1 Hz count-enable tick,
// the counter clear pulse, the display freeze flag and the pause blink.
//
// Ports:
//   CLOCK_50     in   system clock, all logic on the rising edge
//   RESET_N      in   asynchronous active-low reset
//   KEY[1:0]     in   raw buttons, active-low; [1]=start/pause, [0]=lap/clear
//   tick         out  one-cycle count enable, once per CLK_HZ cycles in RUN/LAP
//   count_clr    out  one-cycle pulse on every entry into IDLE
//   running      out  high in RUN and LAP
//   display_hold out  high in LAP (display frozen, counting continues)
//   blink        out  half-second square wave in PAUSE, 0 elsewhere
//   state_dbg    out  encoded state: 0=IDLE 1=RUN 2=PAUSE 3=LAP
// ---------------------------------------------------------------------------
module stopwatch_control_fsm #(
   parameter int CLK_HZ            = 50000000,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [1:0] KEY,
   output logic       tick,
   output logic       count_clr,
   output logic       running,
   output logic       display_hold,
   output logic       blink,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   localparam int HALF_HZ = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
   localparam int PS_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int BL_W    = (HALF_HZ > 1) ? $clog2(HALF_HZ) : 1;
   localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W  = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

   localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(CLK_HZ - 1);
   localparam logic [PS_W-1:0]   PS_ZERO  = PS_W'(1'b0);
   localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1'b1);
   localparam logic [BL_W-1:0]   BL_MAX   = BL_W'(HALF_HZ - 1);
   localparam logic [BL_W-1:0]   BL_ZERO  = BL_W'(1'b0);
   localparam logic [BL_W-1:0]   BL_ONE   = BL_W'(1'b1);
   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_ZERO  = DB_W'(1'b0);
   localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1'b1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(1'b0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);

   // input conditioning
   logic [1:0]      key_meta_r;
   logic [1:0]      key_sync_r;
   logic [1:0]      key_db_r;
   logic [1:0]      key_db_prev_r;
   logic [DB_W-1:0] db_cnt_r [0:1];

   // long-press tracking on KEY[0]
   logic [HOLD_W-1:0] hold_cnt_r;
   logic              long_fired_r;

   // events
   logic start_ev_s;
   logic lap_ev_s;
   logic long_ev_s;

   // FSM
   state_t state_r;
   state_t state_nxt_s;
   logic   goto_idle_s;

   // timing datapath
   logic [PS_W-1:0] presc_r;
   logic [BL_W-1:0] blink_cnt_r;
   logic            tick_r;
   logic            blink_r;
   logic            count_clr_r;
   logic            running_r;
   logic            display_hold_r;

   // Two-flop synchronizer; released level (1) out of reset
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_meta_r <= 2'b11;
         key_sync_r <= 2'b11;
      end else begin
         key_meta_r <= KEY;
         key_sync_r <= key_meta_r;
      end
   end

   // Per-key debounce: a new level is accepted only after it has been seen
   // for DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_db_r      <= 2'b11;
         key_db_prev_r <= 2'b11;
         db_cnt_r[0]   <= DB_ZERO;
         db_cnt_r[1]   <= DB_ZERO;
      end else begin
         key_db_prev_r <= key_db_r;
         for (int i = 0; i < 2; i++) begin
            if (key_sync_r[i] == key_db_r[i]) begin
               db_cnt_r[i] <= DB_ZERO;
            end else if (db_cnt_r[i] == DB_MAX) begin
               key_db_r[i] <= ~key_db_r[i];
               db_cnt_r[i] <= DB_ZERO;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
            end
         end
      end
   end

   // Hold timer for KEY[0]; saturates so long_ev can only fire once per press
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         hold_cnt_r   <= HOLD_ZERO;
         long_fired_r <= 1'b0;
      end else if (!key_db_r[0]) begin
         if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
         end else begin
            long_fired_r <= 1'b1;
         end
      end else begin
         hold_cnt_r   <= HOLD_ZERO;
         long_fired_r <= 1'b0;
      end
   end

   // long_fired_r is still set in the cycle after release, which is what
   // suppresses the lap event of a press that already forced a clear
   assign start_ev_s = key_db_prev_r[1] & ~key_db_r[1];
   assign lap_ev_s   = ~key_db_prev_r[0] & key_db_r[0] & ~long_fired_r;
   assign long_ev_s  = ~key_db_r[0] & (hold_cnt_r == HOLD_MAX) & ~long_fired_r;

   // State register
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; priority long > lap > start, losers are dropped
   always_comb begin
      state_nxt_s = state_r;
      goto_idle_s = 1'b0;
      if (long_ev_s) begin
         state_nxt_s = ST_IDLE;
         goto_idle_s = 1'b1;
      end else if (lap_ev_s) begin
         case (state_r)
            ST_RUN:   state_nxt_s = ST_LAP;
            ST_LAP:   state_nxt_s = ST_RUN;
            ST_PAUSE: begin
               state_nxt_s = ST_IDLE;
               goto_idle_s = 1'b1;
            end
            default:  state_nxt_s = state_r;
         endcase
      end else if (start_ev_s) begin
         case (state_r)
            ST_IDLE:  state_nxt_s = ST_RUN;
            ST_RUN:   state_nxt_s = ST_PAUSE;
            ST_LAP:   state_nxt_s = ST_PAUSE;
            ST_PAUSE: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Prescaler: counts only while the timer runs, frozen in PAUSE so the
   // sub-second fraction survives, zeroed on any entry into IDLE
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_r <= PS_ZERO;
         tick_r  <= 1'b0;
      end else if (goto_idle_s) begin
         presc_r <= PS_ZERO;
         tick_r  <= 1'b0;
      end else if ((state_r == ST_RUN) || (state_r == ST_LAP)) begin
         if (presc_r == PS_MAX) begin
            presc_r <= PS_ZERO;
            tick_r  <= 1'b1;
         end else begin
            presc_r <= presc_r + PS_ONE;
            tick_r  <= 1'b0;
         end
      end else begin
         tick_r <= 1'b0;
      end
   end

   // Pause blink: restarts low on PAUSE entry, toggles every half second
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         blink_cnt_r <= BL_ZERO;
         blink_r     <= 1'b0;
      end else if ((state_nxt_s == ST_PAUSE) && (state_r != ST_PAUSE)) begin
         blink_cnt_r <= BL_ZERO;
         blink_r     <= 1'b0;
      end else if (state_nxt_s == ST_PAUSE) begin
         if (blink_cnt_r == BL_MAX) begin
            blink_cnt_r <= BL_ZERO;
            blink_r     <= ~blink_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + BL_ONE;
         end
      end else begin
         blink_cnt_r <= BL_ZERO;
         blink_r     <= 1'b0;
      end
   end

   // Registered status outputs, aligned with the state register
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         count_clr_r    <= 1'b0;
         running_r      <= 1'b0;
         display_hold_r <= 1'b0;
      end else begin
         count_clr_r    <= goto_idle_s;
         running_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
         display_hold_r <= (state_nxt_s == ST_LAP);
      end
   end

   assign tick         = tick_r;
   assign count_clr    = count_clr_r;
   assign running      = running_r;
   assign display_hold = display_hold_r;
   assign blink        = blink_r;
   assign state_dbg    = state_r;

endmodule

// File: tb/tb_stopwatch_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_control_fsm
//
// Directed bench for stopwatch_control_fsm with CLK_HZ=10, DEBOUNCE_CYCLES=3,
// LONG_PRESS_CYCLES=20. Inputs change and outputs are sampled on the falling
// clock edge. Comments "eN" name the falling edge after the N-th rising edge
// counted from the first key press.
// ---------------------------------------------------------------------------
module tb_stopwatch_control_fsm;

   localparam int ST_IDLE  = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_PAUSE = 2;
   localparam int ST_LAP   = 3;

   logic       CLOCK_50;
   logic       RESET_N;
   logic [1:0] KEY;
   logic       tick;
   logic       count_clr;
   logic       running;
   logic       display_hold;
   logic       blink;
   logic [1:0] state_dbg;

   int errors;
   int checks;

   stopwatch_control_fsm #(
      .CLK_HZ            (10),
      .DEBOUNCE_CYCLES   (3),
      .LONG_PRESS_CYCLES (20)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .RESET_N      (RESET_N),
      .KEY          (KEY),
      .tick         (tick),
      .count_clr    (count_clr),
      .running      (running),
      .display_hold (display_hold),
      .blink        (blink),
      .state_dbg    (state_dbg)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   initial begin
      int seen;
      errors  = 0;
      checks  = 0;
      RESET_N = 1'b0;
      KEY     = 2'b11;

      // reset state
      cyc(3);
      check("rst_state", int'(state_dbg), ST_IDLE);
      check("rst_running", int'(running), 0);
      check("rst_clr", int'(count_clr), 0);
      RESET_N = 1'b1;
      cyc(2);
      check("idle_state", int'(state_dbg), ST_IDLE);
      check("idle_clr", int'(count_clr), 0);

      // clean start press (e0)
      KEY[1] = 1'b0;
      cyc(5);                                       // e5
      check("start_not_yet", int'(running), 0);
      cyc(1);                                       // e6
      check("start_running", int'(running), 1);
      check("start_state", int'(state_dbg), ST_RUN);
      KEY[1] = 1'b1;
      cyc(9);                                       // e15
      check("tick1_early", int'(tick), 0);
      cyc(1);                                       // e16
      check("tick1", int'(tick), 1);
      cyc(1);                                       // e17
      check("tick1_pulse", int'(tick), 0);
      cyc(9);                                       // e26
      check("tick2", int'(tick), 1);

      // bouncing start press -> exactly one event -> PAUSE
      cyc(3);                                       // e29
      KEY[1] = 1'b0; cyc(1);
      KEY[1] = 1'b1; cyc(1);
      KEY[1] = 1'b0; cyc(1);
      KEY[1] = 1'b1; cyc(1);
      KEY[1] = 1'b0;                                // e33
      cyc(5);                                       // e38
      check("bounce_still_run", int'(state_dbg), ST_RUN);
      cyc(1);                                       // e39
      check("pause_state", int'(state_dbg), ST_PAUSE);
      check("pause_running", int'(running), 0);
      check("pause_blink0", int'(blink), 0);
      KEY[1] = 1'b1;
      cyc(4);                                       // e43
      check("blink_hold_low", int'(blink), 0);
      cyc(1);                                       // e44
      check("blink_rise", int'(blink), 1);
      check("pause_no_tick", int'(tick), 0);
      cyc(4);                                       // e48
      check("blink_hold_high", int'(blink), 1);
      cyc(1);                                       // e49
      check("blink_fall", int'(blink), 0);
      check("pause_single_ev", int'(state_dbg), ST_PAUSE);

      // resume: prescaler was frozen at 3, next tick 7 cycles later
      KEY[1] = 1'b0;
      cyc(5);                                       // e54
      check("resume_not_yet", int'(state_dbg), ST_PAUSE);
      cyc(1);                                       // e55
      check("resume_state", int'(state_dbg), ST_RUN);
      check("resume_blink0", int'(blink), 0);
      KEY[1] = 1'b1;
      cyc(6);                                       // e61
      check("resume_tick_early", int'(tick), 0);
      cyc(1);                                       // e62
      check("resume_tick", int'(tick), 1);

      // short lap press: RUN -> LAP on release
      KEY[0] = 1'b0;
      cyc(10);                                      // e72
      KEY[0] = 1'b1;
      cyc(5);                                       // e77
      check("lap_not_yet", int'(state_dbg), ST_RUN);
      check("lap_hold0", int'(display_hold), 0);
      cyc(1);                                       // e78
      check("lap_state", int'(state_dbg), ST_LAP);
      check("lap_hold1", int'(display_hold), 1);
      check("lap_running", int'(running), 1);
      cyc(4);                                       // e82
      check("lap_tick", int'(tick), 1);
      KEY[0] = 1'b0;
      cyc(10);                                      // e92
      KEY[0] = 1'b1;
      cyc(5);                                       // e97
      check("unlap_not_yet", int'(state_dbg), ST_LAP);
      cyc(1);                                       // e98
      check("unlap_state", int'(state_dbg), ST_RUN);
      check("unlap_hold0", int'(display_hold), 0);

      // PAUSE then short lap press -> IDLE with clear pulse
      KEY[1] = 1'b0;
      cyc(6);                                       // e104
      check("pause2_state", int'(state_dbg), ST_PAUSE);
      KEY[1] = 1'b1;
      KEY[0] = 1'b0;
      cyc(10);                                      // e114
      KEY[0] = 1'b1;
      cyc(5);                                       // e119
      check("clr_not_yet", int'(count_clr), 0);
      check("pause2_blink", int'(blink), 1);
      cyc(1);                                       // e120
      check("clr_idle", int'(state_dbg), ST_IDLE);
      check("clr_pulse", int'(count_clr), 1);
      check("clr_running", int'(running), 0);
      check("clr_blink0", int'(blink), 0);
      cyc(1);                                       // e121
      check("clr_one_cycle", int'(count_clr), 0);

      // restart: prescaler was zeroed, so full 10 cycles to first tick
      KEY[1] = 1'b0;
      cyc(6);                                       // e127
      check("restart_state", int'(state_dbg), ST_RUN);
      KEY[1] = 1'b1;
      cyc(8);                                       // e135
      check("restart_tick_e135", int'(tick), 0);
      cyc(1);                                       // e136
      check("restart_tick_e136", int'(tick), 0);
      cyc(1);                                       // e137
      check("restart_tick", int'(tick), 1);

      // long press on KEY[0] -> IDLE at hold count 19
      KEY[0] = 1'b0;
      cyc(24);                                      // e161
      check("long_not_yet", int'(state_dbg), ST_RUN);
      check("long_clr0", int'(count_clr), 0);
      cyc(1);                                       // e162
      check("long_idle", int'(state_dbg), ST_IDLE);
      check("long_clr", int'(count_clr), 1);
      check("long_running", int'(running), 0);
      KEY[1] = 1'b0;
      cyc(1);                                       // e163
      check("long_clr_once", int'(count_clr), 0);
      cyc(4);                                       // e167
      KEY[0] = 1'b1;
      cyc(1);                                       // e168
      check("long_then_run", int'(state_dbg), ST_RUN);
      KEY[1] = 1'b1;
      cyc(5);                                       // e173
      check("no_lap_after_long", int'(state_dbg), ST_RUN);
      check("no_lap_hold", int'(display_hold), 0);

      // async reset mid-RUN with prescaler at 7
      cyc(2);                                       // e175
      RESET_N = 1'b0;
      #1;
      check("arst_state", int'(state_dbg), ST_IDLE);
      check("arst_running", int'(running), 0);
      check("arst_outputs", int'({tick, count_clr, display_hold, blink}), 0);
      cyc(2);
      RESET_N = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         if (tick || count_clr || (state_dbg != 2'd0)) seen++;
      end
      check("post_reset_quiet", seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
